snd_env: RTL and testbench

//  4-voice ADSR envelope controller for the sigma-delta sound block. Holds per-voice

---
 rtl/snd_env_pkg.sv | 32 +++
 rtl/snd_env_step.sv | 68 ++++++
 rtl/snd_env.sv | 236 +++++++++++++++++++++++
 tb/tb_snd_env.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_env_pkg.sv
// snd_env_pkg: shared definitions for the envelope controller.
//  - env_state_t : per-voice envelope phase encodings (IDLE=0 .. RELEASE=4)
//  - register address constants for the CPU-visible envelope register map
//  - GAIN_SUBADDR: sound-block sub-address of a voice's gain register
//  - step_of()   : phase rate -> level step, (rate+1)<<4, range 16..4096
package snd_env_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   localparam logic [1:0] SUB_ATK = 2'd0;
   localparam logic [1:0] SUB_DEC = 2'd1;
   localparam logic [1:0] SUB_SUS = 2'd2;
   localparam logic [1:0] SUB_REL = 2'd3;

   localparam logic [4:0] ADDR_GATE = 5'h10;
   localparam logic [4:0] ADDR_EN   = 5'h11;
   localparam logic [4:0] ADDR_BUSY = 5'h12;
   localparam logic [2:0] ADDR_LVL_HI = 3'b101;  // 0x14..0x17

   localparam logic [1:0] GAIN_SUBADDR = 2'b11;

   function automatic logic [12:0] step_of(input logic [7:0] rate);
      return ({5'd0, rate} + 13'd1) << 4;
   endfunction

endpackage

// File: rtl/snd_env_step.sv
// snd_env_step: combinational envelope step for one voice. Shared by the
// voice scan in snd_env, so it sees one voice per clock.
// Ports:
//  i_state  in  3   current phase (env_state_t encoding)
//  i_level  in  16  current level
//  i_atk    in  8   attack rate
//  i_dec    in  8   decay rate
//  i_rel    in  8   release rate
//  i_sus    in  8   sustain level (target is {i_sus, 8'h00})
//  o_state  out 3   next phase
//  o_level  out 16  next level
import snd_env_pkg::*;

module snd_env_step (
   input  logic [2:0]  i_state,
   input  logic [15:0] i_level,
   input  logic [7:0]  i_atk,
   input  logic [7:0]  i_dec,
   input  logic [7:0]  i_rel,
   input  logic [7:0]  i_sus,
   output logic [2:0]  o_state,
   output logic [15:0] o_level
);

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [12:0] s);
      logic signed [17:0] sum;
      sum = $signed({2'b00, a}) + $signed({5'd0, s});
      if (sum > 18'sd65535) return 16'hFFFF;
      else                  return sum[15:0];
   endfunction

   // Subtract and floor at 'floor'; also pulls a level sitting below the
   // floor up to it (sustain raised while decaying).
   function automatic logic [15:0] clamp_sub(input logic [15:0] a, input logic [12:0] s,
                                             input logic [15:0] floor);
      logic signed [17:0] diff;
      diff = $signed({2'b00, a}) - $signed({5'd0, s});
      if (diff <= $signed({2'b00, floor})) return floor;
      else                                 return diff[15:0];
   endfunction

   logic [15:0] w_lvl;
   logic [15:0] w_tgt;

   assign w_tgt = {i_sus, 8'h00};

   always_comb begin
      o_state = i_state;
      w_lvl   = i_level;
      case (env_state_t'(i_state))
         ST_ATTACK: begin
            w_lvl = sat_add(i_level, step_of(i_atk));
            if (w_lvl == 16'hFFFF) o_state = ST_DECAY;
         end
         ST_DECAY: begin
            w_lvl = clamp_sub(i_level, step_of(i_dec), w_tgt);
            if (w_lvl == w_tgt) o_state = ST_SUSTAIN;
         end
         ST_RELEASE: begin
            w_lvl = clamp_sub(i_level, step_of(i_rel), 16'h0000);
            if (w_lvl == 16'h0000) o_state = ST_IDLE;
         end
         default: ;  // IDLE and SUSTAIN hold
      endcase
      o_level = w_lvl;
   end

endmodule

// File: rtl/snd_env.sv
// snd_env: 4-voice ADSR envelope controller in front of the sound block.
// Keeps per-voice rates/sustain, gate and enable bits; once per tick it scans
// the voices (one per clock through a shared step unit) and schedules gain
// writes into the sound block. CPU sound-block cycles pass straight through
// and always take priority over envelope writes.
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  cs, we, addr[4:0], din   envelope register access
//  dout[7:0]                registered read data
//  cpu_snd_cs/we/addr/din   CPU access to the sound block
//  snd_cs/we/addr/din       sound block bus (combinational mux)
import snd_env_pkg::*;

module snd_env #(
   parameter int TICK_DIV = 16000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [4:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       cpu_snd_cs,
   input  logic       cpu_snd_we,
   input  logic [3:0] cpu_snd_addr,
   input  logic [7:0] cpu_snd_din,
   output logic       snd_cs,
   output logic       snd_we,
   output logic [3:0] snd_addr,
   output logic [7:0] snd_din
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

   logic [7:0]  r_atk [4];
   logic [7:0]  r_dec [4];
   logic [7:0]  r_sus [4];
   logic [7:0]  r_rel [4];
   logic [3:0]  r_gate;
   logic [3:0]  r_en;
   logic [3:0]  r_pend;
   logic [15:0] r_level [4];
   env_state_t  r_state [4];
   logic [7:0]  r_last [4];
   logic [CW-1:0] r_tick;
   logic        r_scan_vld_p0;
   logic [1:0]  r_scan_v_p0;
   logic [1:0]  r_rr;

   logic        w_wrap;
   logic        w_cfg_wr;
   logic        w_gate_wr;
   logic        w_en_wr;
   logic [3:0]  w_rise;
   logic [3:0]  w_gate_hit;
   logic [3:0]  w_scan_hit;
   logic [3:0]  w_wr_hit;
   logic [3:0]  w_busy;
   logic [2:0]  w_nstate;
   logic [15:0] w_nlevel;
   logic        w_found;
   logic [1:0]  w_pick;
   logic        w_issue;
   logic [7:0]  w_rdata;

   assign w_wrap    = (r_tick == TICK_LAST);
   assign w_cfg_wr  = cs && we && !addr[4];
   assign w_gate_wr = cs && we && (addr == ADDR_GATE);
   assign w_en_wr   = cs && we && (addr == ADDR_EN);

   // Gate edges on the write clock; a change on a voice beats that voice's
   // scan slot in the same cycle (its step is simply taken next tick).
   always_comb begin
      w_rise     = '0;
      w_gate_hit = '0;
      w_scan_hit = '0;
      w_wr_hit   = '0;
      w_busy     = '0;
      for (int v = 0; v < 4; v++) begin
         w_rise[v]     = w_gate_wr && din[v] && !r_gate[v];
         w_gate_hit[v] = w_rise[v] ||
                         (w_gate_wr && !din[v] && r_gate[v] && (r_state[v] != ST_IDLE));
         w_scan_hit[v] = r_scan_vld_p0 && (r_scan_v_p0 == 2'(v)) && !w_gate_hit[v];
         w_wr_hit[v]   = w_issue && (w_pick == 2'(v));
         w_busy[v]     = (r_state[v] != ST_IDLE);
      end
   end

   snd_env_step u_step (
      .i_state (r_state[r_scan_v_p0]),
      .i_level (r_level[r_scan_v_p0]),
      .i_atk   (r_atk[r_scan_v_p0]),
      .i_dec   (r_dec[r_scan_v_p0]),
      .i_rel   (r_rel[r_scan_v_p0]),
      .i_sus   (r_sus[r_scan_v_p0]),
      .o_state (w_nstate),
      .o_level (w_nlevel)
   );

   // Round-robin pick, starting with the voice after the last one served.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr;
      for (int k = 1; k <= 4; k++) begin
         if (!w_found && r_pend[r_rr + 2'(k)]) begin
            w_found = 1'b1;
            w_pick  = r_rr + 2'(k);
         end
      end
   end

   assign w_issue = w_found && !cpu_snd_cs;

   always_comb begin
      snd_cs   = 1'b0;
      snd_we   = 1'b0;
      snd_addr = 4'h0;
      snd_din  = 8'h00;
      if (cpu_snd_cs) begin
         snd_cs   = 1'b1;
         snd_we   = cpu_snd_we;
         snd_addr = cpu_snd_addr;
         snd_din  = cpu_snd_din;
      end else if (w_issue) begin
         snd_cs   = 1'b1;
         snd_we   = 1'b1;
         snd_addr = {w_pick, GAIN_SUBADDR};
         snd_din  = r_level[w_pick][15:8];
      end
   end

   always_comb begin
      w_rdata = 8'h00;
      if (!addr[4]) begin
         case (addr[1:0])
            SUB_ATK: w_rdata = r_atk[addr[3:2]];
            SUB_DEC: w_rdata = r_dec[addr[3:2]];
            SUB_SUS: w_rdata = r_sus[addr[3:2]];
            default: w_rdata = r_rel[addr[3:2]];
         endcase
      end else if (addr == ADDR_GATE) begin
         w_rdata = {4'h0, r_gate};
      end else if (addr == ADDR_EN) begin
         w_rdata = {4'h0, r_en};
      end else if (addr == ADDR_BUSY) begin
         w_rdata = {4'h0, w_busy};
      end else if (addr[4:2] == ADDR_LVL_HI) begin
         w_rdata = r_level[addr[1:0]][15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < 4; v++) begin
            r_atk[v] <= '0;
            r_dec[v] <= '0;
            r_sus[v] <= '0;
            r_rel[v] <= '0;
         end
         r_gate <= '0;
         r_en   <= '0;
         dout   <= '0;
      end else begin
         if (w_cfg_wr) begin
            case (addr[1:0])
               SUB_ATK: r_atk[addr[3:2]] <= din;
               SUB_DEC: r_dec[addr[3:2]] <= din;
               SUB_SUS: r_sus[addr[3:2]] <= din;
               default: r_rel[addr[3:2]] <= din;
            endcase
         end
         if (w_gate_wr) r_gate <= din[3:0];
         if (w_en_wr)   r_en   <= din[3:0];
         if (cs && !we) dout   <= w_rdata;
      end
   end

   // Tick counter and scan sequencer: voice v is stepped v+1 clocks after wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick        <= '0;
         r_scan_vld_p0 <= 1'b0;
         r_scan_v_p0   <= 2'd0;
         r_rr          <= 2'd0;
      end else begin
         r_tick <= w_wrap ? '0 : r_tick + CW'(1);
         if (w_wrap) begin
            r_scan_vld_p0 <= 1'b1;
            r_scan_v_p0   <= 2'd0;
         end else if (r_scan_vld_p0) begin
            r_scan_vld_p0 <= (r_scan_v_p0 != 2'd3);
            r_scan_v_p0   <= r_scan_v_p0 + 2'd1;
         end
         if (w_issue) r_rr <= w_pick;
      end
   end

   // Per-voice state, level, pending and last-written gain. When a voice is
   // written and scanned in the same clock, the new gain is compared with the
   // byte going out now, not the stale one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < 4; v++) begin
            r_state[v] <= ST_IDLE;
            r_level[v] <= '0;
            r_last[v]  <= '0;
         end
         r_pend <= '0;
      end else begin
         for (int v = 0; v < 4; v++) begin
            if (w_rise[v]) begin
               r_state[v] <= ST_ATTACK;
            end else if (w_gate_hit[v]) begin
               r_state[v] <= ST_RELEASE;
            end else if (w_scan_hit[v]) begin
               r_state[v] <= env_state_t'(w_nstate);
               r_level[v] <= w_nlevel;
            end

            if (w_en_wr && !din[v]) begin
               r_pend[v] <= 1'b0;
            end else if (w_scan_hit[v] && r_en[v] &&
                         (w_nlevel[15:8] != (w_wr_hit[v] ? r_level[v][15:8] : r_last[v]))) begin
               r_pend[v] <= 1'b1;
            end else if (w_wr_hit[v]) begin
               r_pend[v] <= 1'b0;
            end

            if (w_wr_hit[v]) r_last[v] <= r_level[v][15:8];
         end
      end
   end

endmodule

// File: tb/tb_snd_env.sv
// tb_snd_env: directed scoreboard bench for snd_env with an 8-clock tick.
// Expected gain writes are queued before the stimulus that causes them and
// popped by a monitor whenever the envelope side owns the sound-block bus.
module tb_snd_env;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs, we;
   logic [4:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       cpu_snd_cs, cpu_snd_we;
   logic [3:0] cpu_snd_addr;
   logic [7:0] cpu_snd_din;
   logic       snd_cs, snd_we;
   logic [3:0] snd_addr;
   logic [7:0] snd_din;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t q[$];

   snd_env #(.TICK_DIV(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .cs           (cs),
      .we           (we),
      .addr         (addr),
      .din          (din),
      .dout         (dout),
      .cpu_snd_cs   (cpu_snd_cs),
      .cpu_snd_we   (cpu_snd_we),
      .cpu_snd_addr (cpu_snd_addr),
      .cpu_snd_din  (cpu_snd_din),
      .snd_cs       (snd_cs),
      .snd_we       (snd_we),
      .snd_addr     (snd_addr),
      .snd_din      (snd_din)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] v, input logic [7:0] d);
      wr_t e;
      e.a = {v, 2'b11};
      e.d = d;
      q.push_back(e);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(posedge clk);
      #1;
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
      @(posedge clk);
      #1;
      cs = 1'b1; we = 1'b0; addr = a;
      @(posedge clk);
      #1;
      cs = 1'b0;
      chk(tag, 16'(dout), 16'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic drain(input string tag, input int bound);
      int n;
      n = 0;
      while (q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      checks++;
      assert (q.size() == 0) else begin
         errors++;
         $error("FAIL %s observed_outstanding=%0d expected=0", tag, q.size());
         q.delete();
      end
   endtask

   task automatic chk_bus(input string tag, input logic c, input logic w,
                          input logic [3:0] a, input logic [7:0] d);
      chk({tag, "_cs"},   16'(snd_cs),   16'(c));
      chk({tag, "_we"},   16'(snd_we),   16'(w));
      chk({tag, "_addr"}, 16'(snd_addr), 16'(a));
      chk({tag, "_din"},  16'(snd_din),  16'(d));
   endtask

   // Envelope-owned bus cycles are compared against the scoreboard.
   always @(negedge clk) begin
      if (!rst && !cpu_snd_cs && snd_cs) begin
         if (q.size() == 0) begin
            checks++;
            assert (q.size() != 0) else begin
               errors++;
               $error("FAIL spurious_write observed addr=%0h din=%0h expected none",
                      snd_addr, snd_din);
            end
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", 16'(snd_addr), 16'(e.a));
            chk("wr_din",  16'(snd_din),  16'(e.d));
            chk("wr_we",   16'(snd_we),   16'd1);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
      cpu_snd_cs = 1'b0; cpu_snd_we = 1'b0; cpu_snd_addr = '0; cpu_snd_din = '0;
      idle(3);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk_bus("rst_bus", 1'b0, 1'b0, 4'h0, 8'h00);
      chk("rst_dout", 16'(dout), 16'h0);
      rd(5'h12, 8'h00, "rst_busy");
      rd(5'h14, 8'h00, "rst_level0");
      wr(5'h1F, 8'hAA);
      rd(5'h1F, 8'h00, "unmapped_1F");
      rd(5'h13, 8'h00, "unmapped_13");

      // Attack 0 -> 0xFFFF at 4096/tick, then decay 256/tick to 0x8000
      wr(5'h00, 8'hFF);
      wr(5'h01, 8'h0F);
      wr(5'h02, 8'h80);
      wr(5'h03, 8'hFF);
      wr(5'h11, 8'h01);
      for (int i = 1; i <= 15; i++) push(2'd0, 8'(i * 16));
      push(2'd0, 8'hFF);
      for (int d = 254; d >= 128; d--) push(2'd0, 8'(d));
      wr(5'h10, 8'h01);
      drain("attack_decay", 1500);
      idle(40);
      rd(5'h12, 8'h01, "sustain_busy");
      rd(5'h14, 8'h80, "sustain_level");

      // Release 0x8000 -> 0 in 8 ticks
      for (int i = 7; i >= 0; i--) push(2'd0, 8'(i * 16));
      wr(5'h10, 8'h00);
      drain("release", 200);
      idle(24);
      rd(5'h12, 8'h00, "release_busy");
      rd(5'h14, 8'h00, "release_level");

      // Gate on during release at 0x4000 resumes attack from there
      wr(5'h02, 8'hFF);
      for (int i = 1; i <= 8; i++) push(2'd0, 8'(i * 16));
      wr(5'h10, 8'h01);
      drain("attack_to_8000", 150);
      for (int i = 7; i >= 4; i--) push(2'd0, 8'(i * 16));
      wr(5'h10, 8'h00);
      drain("release_to_4000", 100);
      for (int i = 5; i <= 15; i++) push(2'd0, 8'(i * 16));
      push(2'd0, 8'hFF);
      wr(5'h10, 8'h01);
      drain("reattack", 200);
      idle(40);
      rd(5'h12, 8'h01, "reattack_busy");
      rd(5'h14, 8'hFF, "reattack_level");

      // env_en=0: levels and busy evolve, nothing is written
      wr(5'h11, 8'h00);
      wr(5'h04, 8'hFF); wr(5'h05, 8'h0F); wr(5'h06, 8'hA0);
      wr(5'h08, 8'hFF); wr(5'h09, 8'h0F); wr(5'h0A, 8'hE0);
      wr(5'h0C, 8'hFF); wr(5'h0D, 8'h0F); wr(5'h0E, 8'hC0);
      wr(5'h10, 8'h0E);
      rd(5'h12, 8'h0F, "en_off_busy_early");
      idle(1200);
      rd(5'h12, 8'h0E, "en_off_busy_late");
      rd(5'h14, 8'h00, "en_off_level0");
      rd(5'h15, 8'hA0, "en_off_level1");
      rd(5'h16, 8'hE0, "en_off_level2");
      rd(5'h17, 8'hC0, "en_off_level3");

      // CPU holds the bus while all four voices go pending
      @(posedge clk);
      #1;
      cpu_snd_cs = 1'b1; cpu_snd_we = 1'b1; cpu_snd_addr = 4'h5; cpu_snd_din = 8'hA5;
      @(negedge clk);
      chk_bus("cpu_mirror_a", 1'b1, 1'b1, 4'h5, 8'hA5);
      push(2'd1, 8'hA0);
      push(2'd2, 8'hE0);
      push(2'd3, 8'hC0);
      push(2'd0, 8'h00);
      wr(5'h11, 8'h0F);
      idle(24);
      #1;
      cpu_snd_we = 1'b0; cpu_snd_addr = 4'hA; cpu_snd_din = 8'h3C;
      @(negedge clk);
      chk_bus("cpu_mirror_b", 1'b1, 1'b0, 4'hA, 8'h3C);
      @(posedge clk);
      #1;
      cpu_snd_cs = 1'b0; cpu_snd_addr = 4'h0; cpu_snd_din = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_consecutive_cs", 16'(snd_cs), 16'd1);
      end
      drain("rr_burst", 10);
      @(negedge clk);
      chk("rr_after_cs", 16'(snd_cs), 16'd0);

      // Reset mid-attack with a write held pending behind the CPU
      @(posedge clk);
      #1;
      cpu_snd_cs = 1'b1;
      wr(5'h10, 8'h01);
      idle(12);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cpu_snd_cs = 1'b0;
      @(negedge clk);
      chk_bus("post_rst_bus", 1'b0, 1'b0, 4'h0, 8'h00);
      chk("post_rst_dout", 16'(dout), 16'h0);
      idle(40);
      rd(5'h12, 8'h00, "post_rst_busy");
      rd(5'h14, 8'h00, "post_rst_level0");
      rd(5'h15, 8'h00, "post_rst_level1");
      drain("post_rst_queue", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
